roi_pixel_streamer: RTL and testbench

//  Source side of the hessian conv pixel stream. On start, fetches a ROI_SIZE x ROI_SIZE window at
//  (roi_x, roi_y) from the frame buffer and emits it raster-order, NUM_PER_CYCLE pixels per beat.

---
 rtl/roi_pixel_streamer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_roi_pixel_streamer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roi_pixel_streamer.sv
// ============================================================================
// roi_pixel_streamer
// ----------------------------------------------------------------------------
// Purpose:
//   Feeds the hessian convolution with a ROI_SIZE x ROI_SIZE window taken
//   from the frame buffer at (roi_x, roi_y). Pixels go out in raster order,
//   NUM_PER_CYCLE pixels per beat. Any part of the window that falls outside
//   the frame is sent as zero pixels. The frame buffer is a BRAM with a
//   one-cycle read latency. A two-entry FIFO absorbs consumer back-pressure
//   and still sustains one beat per cycle while ready_in stays high.
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset. It is synchronised
//                  internally, so the block leaves reset two clocks after
//                  release.
//   clk_en_i       global enable; when low every functional register holds
//   start_i        one-cycle request, sampled only while idle
//   roi_x_i        signed ROI left column; low log2(NPC) bits are ignored
//   roi_y_i        signed ROI top row; may be negative or past the frame
//   mem_rd_en_o    BRAM read strobe; asserted only for in-frame words
//   mem_addr_o     BRAM word address = row*(FRAME_W/NPC) + col/NPC
//   mem_rdata_i    BRAM word; pixel n at [n*IN_WIDTH +: IN_WIDTH]
//   dout_o         beat pixels; dout_o[n] = pixel at column roi_x+col+n
//   dout_valid_o   a beat is available on dout_o
//   ready_in_i     consumer ready; the beat moves on valid & ready & clk_en
//   busy_o         high while a ROI is being fetched or drained
//   done_o         one-cycle pulse after the final beat has moved
// ============================================================================
module roi_pixel_streamer #(
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480,
    parameter int ROI_SIZE      = 470,
    parameter int IN_WIDTH      = 12,
    parameter int NUM_PER_CYCLE = 2,
    parameter int ADDR_W        = $clog2(FRAME_W * FRAME_H / NUM_PER_CYCLE),
    parameter int CW            = $clog2(FRAME_W) + 2,
    parameter int RW            = $clog2(FRAME_H) + 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n_i,
    input  logic                                     clk_en_i,
    input  logic                                     start_i,
    input  logic signed [CW-1:0]                     roi_x_i,
    input  logic signed [RW-1:0]                     roi_y_i,
    output logic                                     mem_rd_en_o,
    output logic        [ADDR_W-1:0]                 mem_addr_o,
    input  logic        [NUM_PER_CYCLE*IN_WIDTH-1:0] mem_rdata_i,
    output logic        [NUM_PER_CYCLE-1:0][IN_WIDTH-1:0] dout_o,
    output logic                                     dout_valid_o,
    input  logic                                     ready_in_i,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam int NPC_SHIFT     = $clog2(NUM_PER_CYCLE);
    localparam int CNT_W         = $clog2(ROI_SIZE + 1);
    localparam int WORDS_PER_ROW = FRAME_W / NUM_PER_CYCLE;
    localparam int BEAT_W        = NUM_PER_CYCLE * IN_WIDTH;
    // Absolute coordinates need room for the signed origin plus the largest
    // in-window offset without wrapping.
    localparam int XW            = ((CW > CNT_W) ? CW : CNT_W) + 2;
    localparam int YW            = ((RW > CNT_W) ? RW : CNT_W) + 2;

    localparam logic signed [XW-1:0] X_LIMIT = XW'(FRAME_W);
    localparam logic signed [YW-1:0] Y_LIMIT = YW'(FRAME_H);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(ROI_SIZE - NUM_PER_CYCLE);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ROI_SIZE - 1);
    localparam logic [CNT_W-1:0] COL_STEP  = CNT_W'(NUM_PER_CYCLE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------------
    // Internal reset. Assertion takes effect at once. Release is lined up to
    // the clock so that every register leaves reset on the same edge.
    // ------------------------------------------------------------------------
    logic [1:0] rstSync_q;
    logic       rstInt_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]              state_q, state_d;
    logic signed [CW-1:0]    roiX_q;
    logic signed [RW-1:0]    roiY_q;
    logic [CNT_W-1:0]        rowCnt_q, rowCnt_d;
    logic [CNT_W-1:0]        colCnt_q, colCnt_d;
    logic                    pendValid_q;
    logic                    pendZero_q;
    logic [BEAT_W-1:0]       fifoMem_q [2];
    logic                    wrPtr_q;
    logic                    rdPtr_q;
    logic [1:0]              fifoCount_q;
    logic                    done_q;

    logic signed [XW-1:0]    xAbs;
    logic signed [YW-1:0]    yAbs;
    logic                    inFrame;
    logic                    popBeat;
    logic                    pushBeat;
    logic [BEAT_W-1:0]       pushData;
    logic                    fetchRoom;
    logic                    fetchGo;
    logic                    lastFetch;
    logic                    startAccept;
    logic                    drainDone;
    logic [ADDR_W-1:0]       rowBase;
    logic [ADDR_W-1:0]       wordCol;

    // ------------------------------------------------------------------------
    // Fetch position and frame test. The beat at the current counters is
    // either fully inside or fully outside the frame, because both the ROI
    // origin and the frame width are multiples of NUM_PER_CYCLE.
    // ------------------------------------------------------------------------
    always_comb begin
        xAbs    = XW'(roiX_q) + $signed(XW'(colCnt_q));
        yAbs    = YW'(roiY_q) + $signed(YW'(rowCnt_q));
        inFrame = !xAbs[XW-1] && (xAbs < X_LIMIT) &&
                  !yAbs[YW-1] && (yAbs < Y_LIMIT);
        rowBase = ADDR_W'(yAbs) * ADDR_W'(WORDS_PER_ROW);
        wordCol = ADDR_W'(xAbs >>> NPC_SHIFT);
    end

    // ------------------------------------------------------------------------
    // Flow control. A fetch is issued only if its result is sure to find a
    // FIFO slot. The beat leaving this cycle is counted as free space, which
    // is what lets a two-entry FIFO keep up with one beat per cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        popBeat     = dout_valid_o && ready_in_i && clk_en_i;
        pushBeat    = pendValid_q;
        pushData    = pendZero_q ? '0 : mem_rdata_i;
        fetchRoom   = ({1'b0, fifoCount_q} + {2'b00, pendValid_q}) <=
                      (3'd1 + {2'b00, popBeat});
        fetchGo     = (state_q == ST_RUN) && clk_en_i && fetchRoom;
        lastFetch   = (rowCnt_q == ROW_LAST) && (colCnt_q == COL_LAST);
        // Do not accept a start while done is still showing. That way a
        // start that arrives in the same cycle as done belongs to the
        // finished ROI and is dropped.
        startAccept = (state_q == ST_IDLE) && start_i && !done_q;
        drainDone   = (state_q == ST_DRAIN) && !pendValid_q &&
                      (fifoCount_q == {1'b0, popBeat});
    end

    // ------------------------------------------------------------------------
    // Sequencer and raster counters. RUN walks the window one beat per
    // issued fetch. DRAIN waits for the last beat to leave before going
    // back to idle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rowCnt_d = rowCnt_q;
        colCnt_d = colCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (startAccept) begin
                    state_d  = ST_RUN;
                    rowCnt_d = '0;
                    colCnt_d = '0;
                end
            end
            ST_RUN: begin
                if (fetchGo) begin
                    if (colCnt_q == COL_LAST) begin
                        colCnt_d = '0;
                        rowCnt_d = rowCnt_q + CNT_W'(1);
                    end else begin
                        colCnt_d = colCnt_q + COL_STEP;
                    end
                    if (lastFetch) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drainDone) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Register update. Everything freezes when clk_en is low, including the
    // one-deep in-flight stage that tracks the BRAM read latency.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q     <= ST_IDLE;
            roiX_q      <= '0;
            roiY_q      <= '0;
            rowCnt_q    <= '0;
            colCnt_q    <= '0;
            pendValid_q <= 1'b0;
            pendZero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else if (clk_en_i) begin
            state_q     <= state_d;
            rowCnt_q    <= rowCnt_d;
            colCnt_q    <= colCnt_d;
            // Every fetch goes through the in-flight stage, including a
            // zero beat for an out-of-frame position. Padding therefore
            // takes the same slot order as real reads.
            pendValid_q <= fetchGo;
            pendZero_q  <= !inFrame;
            done_q      <= drainDone;
            if (startAccept) begin
                roiX_q <= roi_x_i & ~CW'(NUM_PER_CYCLE - 1);
                roiY_q <= roi_y_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry output FIFO. The head entry drives dout_o directly, so a
    // stalled beat stays unchanged on the outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstInt_n) begin
        if (!rstInt_n) begin
            fifoMem_q[0] <= '0;
            fifoMem_q[1] <= '0;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            fifoCount_q  <= 2'd0;
        end else if (clk_en_i) begin
            if (pushBeat) begin
                fifoMem_q[wrPtr_q] <= pushData;
                wrPtr_q            <= ~wrPtr_q;
            end
            if (popBeat) begin
                rdPtr_q <= ~rdPtr_q;
            end
            fifoCount_q <= fifoCount_q + 2'(pushBeat) - 2'(popBeat);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The address is forced to zero unless a real read is issued.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_rd_en_o  = fetchGo && inFrame;
        mem_addr_o   = mem_rd_en_o ? (rowBase + wordCol) : '0;
        dout_o       = fifoMem_q[rdPtr_q];
        dout_valid_o = (fifoCount_q != 2'd0);
        busy_o       = (state_q != ST_IDLE);
        done_o       = done_q;
    end

endmodule

// File: tb/tb_roi_pixel_streamer.sv
// ============================================================================
// tb_roi_pixel_streamer
// ----------------------------------------------------------------------------
// Directed bench for roi_pixel_streamer in its small build: a 16x12 frame,
// an 8x8 ROI and two pixels per beat. The frame memory holds pixel
// (row, col) = row*16 + col. Expected beats come from a small window model.
// ============================================================================
module tb_roi_pixel_streamer;

    localparam int FRAME_W  = 16;
    localparam int FRAME_H  = 12;
    localparam int ROI_SIZE = 8;
    localparam int IN_WIDTH = 12;
    localparam int NPC      = 2;
    localparam int ADDR_W   = 7;
    localparam int CW       = 6;
    localparam int RW       = 6;
    localparam int BEATS    = ROI_SIZE * ROI_SIZE / NPC;

    logic                          clk;
    logic                          rst_n;
    logic                          clk_en;
    logic                          start;
    logic signed [CW-1:0]          roi_x;
    logic signed [RW-1:0]          roi_y;
    logic                          mem_rd_en;
    logic [ADDR_W-1:0]             mem_addr;
    logic [NPC*IN_WIDTH-1:0]       mem_rdata;
    logic [NPC-1:0][IN_WIDTH-1:0]  dout;
    logic                          dout_valid;
    logic                          ready_in;
    logic                          busy;
    logic                          done;
    logic [23:0]                   doutFlat;

    int errors = 0;
    int checks = 0;

    logic [23:0] frameMem [96];
    logic [23:0] gotBeat [64];
    int gotCount, doneCount, doneCycle, readCount, badRead, stallBad;
    int firstValid, firstRead, timedOut, busyAfterDone, readAfterDone;

    roi_pixel_streamer #(
        .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .ROI_SIZE(ROI_SIZE),
        .IN_WIDTH(IN_WIDTH), .NUM_PER_CYCLE(NPC), .ADDR_W(ADDR_W),
        .CW(CW), .RW(RW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .start_i(start),
        .roi_x_i(roi_x), .roi_y_i(roi_y),
        .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .dout_o(dout), .dout_valid_o(dout_valid), .ready_in_i(ready_in),
        .busy_o(busy), .done_o(done)
    );

    assign doutFlat = dout;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame buffer preload: word = {pixel(col+1), pixel(col)}
    initial begin
        for (int r = 0; r < FRAME_H; r++) begin
            for (int w = 0; w < FRAME_W / NPC; w++) begin
                frameMem[r*8 + w] = {12'(r*16 + 2*w + 1), 12'(r*16 + 2*w)};
            end
        end
    end

    // BRAM with one-cycle latency that holds its data while clk_en is low
    always_ff @(posedge clk) begin
        if (clk_en && mem_rd_en) begin
            mem_rdata <= frameMem[mem_addr];
        end
    end

    // Window model: expected beat idx for ROI origin (rx, ry)
    function automatic logic [23:0] expBeat(input int rx, input int ry, input int idx);
        logic [11:0] p [2];
        int x, y;
        for (int n = 0; n < 2; n++) begin
            x = rx + (idx % 4) * 2 + n;
            y = ry + idx / 4;
            if (x >= 0 && x < FRAME_W && y >= 0 && y < FRAME_H) p[n] = 12'(y*16 + x);
            else p[n] = 12'd0;
        end
        return {p[1], p[0]};
    endfunction

    // Model: number of in-frame words in the ROI
    function automatic int expReads(input int rx, input int ry);
        int cnt = 0;
        for (int r = 0; r < ROI_SIZE; r++) begin
            for (int c = 0; c < ROI_SIZE; c += NPC) begin
                if (rx + c >= 0 && rx + c < FRAME_W && ry + r >= 0 && ry + r < FRAME_H) cnt++;
            end
        end
        return cnt;
    endfunction

    // Starts one ROI and records what the DUT does until a few cycles after
    // done. Mode 0: ready held high. Mode 1: ready random. Mode 2: clk_en low
    // on every third cycle, periodic ready stalls, and a start pulse mid-run.
    task automatic runRoi(input int rx, input int ry, input int mode, input bit startOnDone);
        int cyc;
        int extra;
        bit held;
        logic [23:0] heldBeat;
        gotCount = 0; doneCount = 0; doneCycle = -1; readCount = 0; badRead = 0;
        stallBad = 0; firstValid = -1; firstRead = -1; timedOut = 0;
        busyAfterDone = 0; readAfterDone = 0;
        held = 1'b0; heldBeat = '0; extra = 0; cyc = 0;
        @(negedge clk);
        roi_x = CW'(rx); roi_y = RW'(ry);
        start = 1'b1; ready_in = 1'b1; clk_en = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            case (mode)
                1: begin ready_in = 1'($urandom_range(0, 1)); clk_en = 1'b1; end
                2: begin
                    clk_en   = (cyc % 3 != 0);
                    ready_in = (cyc % 4 != 1);
                    if (cyc == 10) start = 1'b1;
                end
                default: begin ready_in = 1'b1; clk_en = 1'b1; end
            endcase
            #1;
            if (held && (!dout_valid || doutFlat != heldBeat)) stallBad++;
            if (dout_valid && firstValid < 0) firstValid = cyc;
            if (mem_rd_en) begin
                readCount++;
                if (firstRead < 0) firstRead = cyc;
                if (!clk_en || mem_addr >= 7'd96) badRead++;
            end
            if (doneCycle >= 0 && cyc == doneCycle + 1) begin
                busyAfterDone = busy;
                readAfterDone = mem_rd_en;
            end
            if (done && clk_en) begin
                doneCount++;
                doneCycle = cyc;
                if (startOnDone) start = 1'b1;
            end
            if (dout_valid && ready_in && clk_en) begin
                if (gotCount < 64) gotBeat[gotCount] = doutFlat;
                gotCount++;
            end
            held = dout_valid && !(ready_in && clk_en);
            heldBeat = doutFlat;
            if (doneCount > 0) extra++;
            if (extra >= 4) break;
            if (cyc >= 1500) begin timedOut = 1; break; end
        end
        @(negedge clk);
        start = 1'b0; ready_in = 1'b1; clk_en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; ready_in = 1'b1;
        roi_x = '0; roi_y = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dout_valid, busy, done, mem_rd_en} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {dout_valid, busy, done, mem_rd_en});
        end
        checks++;
        if (doutFlat !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_dout: got %h expected 000000", doutFlat);
        end
        checks++;
        if (mem_addr !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %0d expected 0", mem_addr);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_in_frame();
        runRoi(4, 2, 0, 1'b0);
        checks++;
        if (timedOut !== 0) begin errors++; $display("[TB] FAIL inframe_timeout: got %0d expected 0", timedOut); end
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL inframe_count: got %0d expected %0d", gotCount, BEATS); end
        checks++;
        if (firstRead !== 1) begin errors++; $display("[TB] FAIL inframe_first_read: got %0d expected 1", firstRead); end
        checks++;
        if (firstValid !== 3) begin errors++; $display("[TB] FAIL inframe_first_valid: got %0d expected 3", firstValid); end
        checks++;
        if (gotBeat[0] !== {12'd37, 12'd36}) begin errors++; $display("[TB] FAIL inframe_beat0: got %h expected %h", gotBeat[0], {12'd37, 12'd36}); end
        checks++;
        if (gotBeat[31] !== {12'd155, 12'd154}) begin errors++; $display("[TB] FAIL inframe_last: got %h expected %h", gotBeat[31], {12'd155, 12'd154}); end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (gotBeat[i] !== expBeat(4, 2, i)) begin errors++; $display("[TB] FAIL inframe_beat%0d: got %h expected %h", i, gotBeat[i], expBeat(4, 2, i)); end
        end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL inframe_done_count: got %0d expected 1", doneCount); end
        checks++;
        if (doneCycle !== 35) begin errors++; $display("[TB] FAIL inframe_done_cycle: got %0d expected 35", doneCycle); end
        checks++;
        if (readCount !== 32) begin errors++; $display("[TB] FAIL inframe_reads: got %0d expected 32", readCount); end
    endtask

    task automatic test_negative_origin();
        runRoi(-2, -1, 0, 1'b0);
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL neg_count: got %0d expected %0d", gotCount, BEATS); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gotBeat[i] !== 24'h0) begin errors++; $display("[TB] FAIL neg_row0_beat%0d: got %h expected 000000", i, gotBeat[i]); end
        end
        checks++;
        if (gotBeat[4] !== 24'h0) begin errors++; $display("[TB] FAIL neg_row1_beat0: got %h expected 000000", gotBeat[4]); end
        checks++;
        if (gotBeat[5] !== {12'd1, 12'd0}) begin errors++; $display("[TB] FAIL neg_row1_beat1: got %h expected %h", gotBeat[5], {12'd1, 12'd0}); end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (gotBeat[i] !== expBeat(-2, -1, i)) begin errors++; $display("[TB] FAIL neg_beat%0d: got %h expected %h", i, gotBeat[i], expBeat(-2, -1, i)); end
        end
        checks++;
        if (readCount !== 21) begin errors++; $display("[TB] FAIL neg_reads: got %0d expected 21", readCount); end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL neg_done_count: got %0d expected 1", doneCount); end
    endtask

    task automatic test_far_corner();
        runRoi(12, 8, 0, 1'b0);
        checks++;
        if (gotBeat[0] !== {12'd141, 12'd140}) begin errors++; $display("[TB] FAIL corner_beat0: got %h expected %h", gotBeat[0], {12'd141, 12'd140}); end
        checks++;
        if (gotBeat[2] !== 24'h0) begin errors++; $display("[TB] FAIL corner_beat2: got %h expected 000000", gotBeat[2]); end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (gotBeat[i] !== expBeat(12, 8, i)) begin errors++; $display("[TB] FAIL corner_beat%0d: got %h expected %h", i, gotBeat[i], expBeat(12, 8, i)); end
        end
        checks++;
        if (readCount !== 8) begin errors++; $display("[TB] FAIL corner_reads: got %0d expected 8", readCount); end
        checks++;
        if (badRead !== 0) begin errors++; $display("[TB] FAIL corner_bad_read: got %0d expected 0", badRead); end
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL corner_count: got %0d expected %0d", gotCount, BEATS); end
    endtask

    task automatic test_random_ready();
        runRoi(10, 6, 1, 1'b0);
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected %0d", gotCount, BEATS); end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (gotBeat[i] !== expBeat(10, 6, i)) begin errors++; $display("[TB] FAIL rnd_beat%0d: got %h expected %h", i, gotBeat[i], expBeat(10, 6, i)); end
        end
        checks++;
        if (stallBad !== 0) begin errors++; $display("[TB] FAIL rnd_stall_hold: got %0d expected 0", stallBad); end
        checks++;
        if (readCount !== expReads(10, 6)) begin errors++; $display("[TB] FAIL rnd_reads: got %0d expected %0d", readCount, expReads(10, 6)); end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL rnd_done_count: got %0d expected 1", doneCount); end
    endtask

    task automatic test_clk_en();
        runRoi(4, 2, 2, 1'b0);
        checks++;
        if (timedOut !== 0) begin errors++; $display("[TB] FAIL clken_timeout: got %0d expected 0", timedOut); end
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL clken_count: got %0d expected %0d", gotCount, BEATS); end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (gotBeat[i] !== expBeat(4, 2, i)) begin errors++; $display("[TB] FAIL clken_beat%0d: got %h expected %h", i, gotBeat[i], expBeat(4, 2, i)); end
        end
        checks++;
        if (stallBad !== 0) begin errors++; $display("[TB] FAIL clken_stall_hold: got %0d expected 0", stallBad); end
        checks++;
        if (badRead !== 0) begin errors++; $display("[TB] FAIL clken_bad_read: got %0d expected 0", badRead); end
        checks++;
        if (readCount !== 32) begin errors++; $display("[TB] FAIL clken_reads: got %0d expected 32", readCount); end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL clken_done_count: got %0d expected 1", doneCount); end
    endtask

    task automatic test_back_to_back();
        runRoi(6, 4, 0, 1'b1);
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", gotCount, BEATS); end
        checks++;
        if (busyAfterDone !== 0) begin errors++; $display("[TB] FAIL b2b_start_on_done_busy: got %0d expected 0", busyAfterDone); end
        checks++;
        if (readAfterDone !== 0) begin errors++; $display("[TB] FAIL b2b_start_on_done_read: got %0d expected 0", readAfterDone); end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", doneCount); end
        runRoi(0, 0, 0, 1'b0);
        checks++;
        if (firstValid !== 3) begin errors++; $display("[TB] FAIL b2b_second_first_valid: got %0d expected 3", firstValid); end
        for (int i = 0; i < BEATS; i++) begin
            checks++;
            if (gotBeat[i] !== expBeat(0, 0, i)) begin errors++; $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, gotBeat[i], expBeat(0, 0, i)); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int moved = 0;
        int cyc = 0;
        int sawDone = 0;
        @(negedge clk);
        roi_x = CW'(4); roi_y = RW'(2); start = 1'b1; ready_in = 1'b1; clk_en = 1'b1;
        while (moved < 10 && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            #1;
            if (dout_valid && ready_in && clk_en) moved++;
        end
        checks++;
        if (moved !== 10) begin errors++; $display("[TB] FAIL midrst_reach_10: got %0d expected 10", moved); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_valid, busy, done, mem_rd_en} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl: got %b expected 0000", {dout_valid, busy, done, mem_rd_en});
        end
        checks++;
        if (doutFlat !== 24'h0) begin errors++; $display("[TB] FAIL midrst_dout: got %h expected 000000", doutFlat); end
        repeat (3) begin
            @(negedge clk);
            if (done) sawDone++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) sawDone++;
        end
        checks++;
        if (sawDone !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", sawDone); end
        runRoi(0, 0, 0, 1'b0);
        checks++;
        if (gotBeat[0] !== {12'd1, 12'd0}) begin errors++; $display("[TB] FAIL midrst_restart_beat0: got %h expected %h", gotBeat[0], {12'd1, 12'd0}); end
        checks++;
        if (gotCount !== BEATS) begin errors++; $display("[TB] FAIL midrst_restart_count: got %0d expected %0d", gotCount, BEATS); end
        checks++;
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL midrst_restart_done: got %0d expected 1", doneCount); end
    endtask

    initial begin
        $display("[TB] roi_pixel_streamer directed bench");
        test_reset();
        test_in_frame();
        test_negative_origin();
        test_far_corner();
        test_random_ready();
        test_clk_en();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
